// File: rtl/mds_ram_fetch.sv
// Coefficient RAM fetcher for the MDS bus stage: reads W words per mode,
// buffers them in a 2-entry FIFO and hands them out over a valid/ready bus.
module mds_ram_fetch #(
  parameter int unsigned WORDS_LOG2 = 2,
  parameter int unsigned ADDR_W     = 3 + WORDS_LOG2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2:0]            alg_mode,
  output logic                  busy,
  output logic                  done,
  output logic                  ram_en,
  output logic [ADDR_W-1:0]     ram_addr,
  input  logic [31:0]           ram_rdata,
  output logic [31:0]           ram_data,
  output logic                  ram_data_valid,
  input  logic                  ram_data_ready,
  output logic [WORDS_LOG2-1:0] word_idx
);

  localparam int unsigned W = 2 ** WORDS_LOG2;
  localparam logic [WORDS_LOG2-1:0] LAST = WORDS_LOG2'(W - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t                state_q, state_d;
  logic [2:0]            mode_q;
  logic [WORDS_LOG2-1:0] issue_cnt;
  logic [WORDS_LOG2-1:0] pop_cnt;
  logic                  inflight;
  logic                  done_q;
  logic                  accept;

  logic [31:0]           mem [2];
  logic                  wr_ptr, rd_ptr;
  logic [1:0]            count;
  logic [31:0]           data_q;
  logic [31:0]           head_d;
  logic                  push, pop;
  logic [2:0]            credit;

  assign push           = inflight;
  assign ram_data_valid = (count != 2'd0);
  assign pop            = ram_data_valid && ram_data_ready;
  assign credit         = 3'(count) + 3'(inflight) - 3'(pop);

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign ram_addr = ADDR_W'({mode_q, issue_cnt});
  assign ram_data = data_q;
  assign word_idx = pop_cnt;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    ram_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          accept  = 1'b1;
        end
      end
      FETCH: begin
        // Counting the same-cycle pop frees a slot immediately for full rate.
        ram_en = (credit < 3'd2);
        if (ram_en && issue_cnt == LAST) state_d = DRAIN;
      end
      DRAIN: begin
        if (pop && pop_cnt == LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mode_q    <= '0;
      issue_cnt <= '0;
      pop_cnt   <= '0;
      inflight  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      inflight <= ram_en;
      done_q   <= (state_q == DRAIN) && pop && (pop_cnt == LAST);
      if (accept) begin
        mode_q    <= alg_mode;
        issue_cnt <= '0;
        pop_cnt   <= '0;
      end else begin
        if (ram_en) issue_cnt <= issue_cnt + WORDS_LOG2'(1);
        if (pop)    pop_cnt   <= pop_cnt + WORDS_LOG2'(1);
      end
    end
  end

  // Output register tracks what the FIFO head will be after this cycle.
  always_comb begin
    head_d = data_q;
    if (pop) begin
      if (count == 2'd2) head_d = mem[~rd_ptr];
      else if (push)     head_d = ram_rdata;
    end else if (count == 2'd0 && push) begin
      head_d = ram_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
      data_q <= '0;
    end else if (accept) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count  <= count + 2'(push) - 2'(pop);
      data_q <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !accept) mem[wr_ptr] <= ram_rdata;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && count == 2'd2));

endmodule

// File: doc/mds_ram_fetch.md
# mds_ram_fetch

Upstream feeder for the MDS bus stage. On a start request it reads the MDS coefficient words for the selected algorithm mode from a synchronous single-port coefficient RAM. It buffers them in a 2-entry FIFO that absorbs the RAM read latency and downstream back-pressure. It then presents them one at a time on the 32-bit `ram_data` bus that the MDS bus stage widens to 64 bits.

## Interface
Parameters:
- `WORDS_LOG2`, default 2: log2 of MDS words per algorithm mode; words per mode `W = 2**WORDS_LOG2`.
- `ADDR_W`, default `3+WORDS_LOG2`: RAM address width. Fixed by the formula; do not override.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: fetch request, sampled only in IDLE.
- `alg_mode`  in  3: algorithm mode, latched when `start` is accepted.
- `busy`  out  1: high while state is not IDLE.
- `done`  out  1: one-cycle pulse after the last word is accepted downstream.
- `ram_en`  out  1: RAM read enable.
- `ram_addr`  out  ADDR_W: RAM read address.
- `ram_rdata`  in  32: RAM read data, valid the cycle after `ram_en`.
- `ram_data`  out  32: FIFO head, to the MDS bus stage.
- `ram_data_valid`  out  1: `ram_data` holds a valid word.
- `ram_data_ready`  in  1: downstream accepts the word; transfer = valid & ready.
- `word_idx`  out  WORDS_LOG2: index of the word currently on `ram_data` within its mode.

## Operation
- States: IDLE, FETCH, DRAIN.
  - IDLE → FETCH when `start`=1. Latch `alg_mode` into `mode_q`; clear `issue_cnt`, `pop_cnt`, FIFO.
  - FETCH → DRAIN when the read with `issue_cnt`=W−1 is issued.
  - DRAIN → IDLE when the transfer with `pop_cnt`=W−1 occurs. `done` is registered and goes high in the first IDLE cycle.
- `start` in FETCH or DRAIN is ignored. It is not queued.
- `ram_addr` = {`mode_q`, `issue_cnt`[WORDS_LOG2−1:0]}. Mode m reads addresses m·W .. m·W+W−1. Mode 7 ends at 2**ADDR_W−1. No wrap beyond that.
- Credit rule: `ram_en` = FETCH & (`count` + `inflight` − `pop`) < 2.
  - `count` is FIFO occupancy (0..2).
  - `inflight` is 1 if `ram_en` was high the previous cycle.
  - `pop` is the current transfer.
  - This is a combinational path from `ram_data_ready` to `ram_en`. It is permitted and required for full throughput.
- `ram_rdata` is written into the FIFO in the cycle after `ram_en`. The FIFO never overflows. An overflow is an assertion failure.
- FIFO ordering is first-in first-out.
  - Push and pop in the same cycle is allowed at any occupancy ≥1.
  - Push into an empty FIFO makes the word visible the next cycle, with no bypass.
- `ram_data` is the FIFO head and is registered. When `ram_data_valid`=0, `ram_data` holds its last value.
- `word_idx` = `pop_cnt`.
- Reset (any time, including mid-fetch):
  - Outputs go to state IDLE with `busy`=0, `done`=0, `ram_en`=0, `ram_addr`=0, `ram_data`=0, `ram_data_valid`=0, `word_idx`=0.
  - The FIFO and counters are cleared.
  - A RAM response in flight at reset is discarded.

## Timing
- Cycle 0: `start`=1 in IDLE. Cycle 1: FETCH, `busy`=1, `ram_en`=1, addr = base.
- Cycle 2: `ram_rdata`(base) captured. Cycle 3: `ram_data_valid`=1, `word_idx`=0. Start-to-first-valid latency is 3 cycles.
- With `ram_data_ready` held high, throughput is one word per cycle.
  - W=4: words are valid in cycles 3–6 and reads are issued in cycles 1–4.
  - Cycle 7: IDLE, `done`=1, `busy`=0. A `start` in cycle 7 is accepted.
- With `ram_data_ready`=0, at most 2 reads are outstanding plus buffered. `ram_en` stays low until a pop frees credit.
- `ram_data`/`ram_data_valid` are stable while valid & !ready.

## Test plan
- Mode 0, RAM[i]=0xA5A50000+i, ready=1: `ram_en` in cycles 1–4 at addr 0–3. Data 0xA5A50000..03 is valid in cycles 3–6. `done` pulses in cycle 7 only.
- Mode 7, W=4: addresses 28–31 are read, `word_idx` 0–3, no wrap or out-of-range address.
- Ready=0 from cycle 0 to cycle 9, then 1:
  - exactly 2 `ram_en` pulses are issued and the FIFO holds 2 words;
  - `ram_data`=word0 stays stable and valid;
  - after release, all 4 words arrive in order with no loss or duplication.
- Ready toggling 1,0,1,0 from cycle 3: order is preserved, no overflow, `done` one cycle after the 4th transfer.
- `start` pulsed in cycles 2 and 5 during a mode-3 fetch with `alg_mode` changed to 5: ignored, and all addresses stay 12–15.
- `rst_n` low in cycle 4 mid-fetch: all outputs are at reset values immediately. A new start of mode 1 after release delivers addresses 4–7 cleanly, with no stale word.
